mem_access_stage: RTL

- Data-memory access stage downstream of the instruction controller and ALU.
- Consumes the controller's RAM write-enable, RAM-read and regfile write-enable decisions, together with the ALU result (address) and the store data.
- Runs a request/acknowledge transaction with data memory, stalling upstream while the transaction is outstanding.
- Delivers one registered writeback beat per accepted instruction.

---
 rtl/mem_access_stage.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
//
// Data-memory access stage that sits behind the instruction controller and ALU.
// Non-memory instructions are passed straight through to a registered
// writeback beat (1 instruction per cycle, 1-cycle latency). Loads and stores
// run a request/acknowledge transaction with data memory. The stage stalls
// upstream (in_ready low) while that transaction is outstanding, and abandons
// it after TIMEOUT cycles without an acknowledge.
//
// Ports
//   clock, reset            rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready     upstream handshake; in_ready low means stall
//   alu_result, store_data  address (lw/sw) or result, and store data
//   ctrl_ram_we, ctrl_read_ram, ctrl_reg_we, rd
//                           controller decisions and destination register
//   mem_req/we/addr/wdata   data-memory request, held until mem_ack
//   mem_ack, mem_rdata      memory completion and load data
//   wb_valid/reg_we/rd/data one-cycle writeback beat per accepted instruction
//   err_range, err_timeout  sticky error flags, cleared only by reset
// -----------------------------------------------------------------------------
module mem_access_stage #(
    parameter int ADDR_WIDTH = 12,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           alu_result,
    input  logic [31:0]           store_data,
    input  logic                  ctrl_ram_we,
    input  logic                  ctrl_read_ram,
    input  logic                  ctrl_reg_we,
    input  logic [4:0]            rd,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic                  mem_ack,
    input  logic [31:0]           mem_rdata,
    output logic                  wb_valid,
    output logic                  wb_reg_we,
    output logic [4:0]            wb_rd,
    output logic [31:0]           wb_data,
    output logic                  err_range,
    output logic                  err_timeout
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    // The counter only has to reach TIMEOUT-1, and TIMEOUT is at most 65535.
    localparam int              CNT_W    = 16;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t                  state_q,       state_d;
    logic [CNT_W-1:0]        cnt_q,         cnt_d;
    logic                    mem_req_q,     mem_req_d;
    logic                    mem_we_q,      mem_we_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q,    mem_addr_d;
    logic [31:0]             mem_wdata_q,   mem_wdata_d;
    logic [4:0]              req_rd_q,      req_rd_d;
    logic                    wb_valid_q,    wb_valid_d;
    logic                    wb_reg_we_q,   wb_reg_we_d;
    logic [4:0]              wb_rd_q,       wb_rd_d;
    logic [31:0]             wb_data_q,     wb_data_d;
    logic                    err_range_q,   err_range_d;
    logic                    err_timeout_q, err_timeout_d;

    logic                    is_mem_s;
    logic                    out_of_range_s;
    logic                    rd_nz_s;
    logic                    req_rd_nz_s;

    // Decode helpers for the instruction presented this cycle.
    always_comb begin
        // Both enables set is treated as a store; either one makes it a memory op.
        is_mem_s       = ctrl_ram_we | ctrl_read_ram;
        // Any address bit above the memory's word-address range is an error.
        out_of_range_s = ((alu_result >> ADDR_WIDTH) != 32'd0);
        rd_nz_s        = (rd != 5'd0);
        req_rd_nz_s    = (req_rd_q != 5'd0);
    end

    // Next-state and next-output logic for the IDLE/REQ controller.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        mem_req_d     = mem_req_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        req_rd_d      = req_rd_q;
        wb_valid_d    = 1'b0;
        wb_reg_we_d   = 1'b0;
        wb_rd_d       = wb_rd_q;
        wb_data_d     = wb_data_q;
        err_range_d   = err_range_q;
        err_timeout_d = err_timeout_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (!is_mem_s) begin
                        // Plain ALU result: straight to writeback.
                        wb_valid_d  = 1'b1;
                        wb_reg_we_d = ctrl_reg_we & rd_nz_s;
                        wb_rd_d     = rd;
                        wb_data_d   = alu_result;
                    end else if (out_of_range_s) begin
                        // Bad address: no memory request, retire with no write.
                        err_range_d = 1'b1;
                        wb_valid_d  = 1'b1;
                        wb_reg_we_d = 1'b0;
                        wb_rd_d     = rd;
                        wb_data_d   = 32'd0;
                    end else begin
                        state_d     = ST_REQ;
                        cnt_d       = {CNT_W{1'b0}};
                        mem_req_d   = 1'b1;
                        mem_we_d    = ctrl_ram_we;
                        mem_addr_d  = alu_result[ADDR_WIDTH-1:0];
                        mem_wdata_d = ctrl_ram_we ? store_data : 32'd0;
                        req_rd_d    = rd;
                    end
                end else begin
                    wb_valid_d = 1'b0;
                end
            end

            ST_REQ: begin
                // An ack on the final allowed cycle still wins over the timeout.
                if (mem_ack) begin
                    state_d    = ST_IDLE;
                    mem_req_d  = 1'b0;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = req_rd_q;
                    if (mem_we_q) begin
                        wb_reg_we_d = 1'b0;
                        wb_data_d   = 32'd0;
                    end else begin
                        wb_reg_we_d = req_rd_nz_s;
                        wb_data_d   = mem_rdata;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d       = ST_IDLE;
                    mem_req_d     = 1'b0;
                    err_timeout_d = 1'b1;
                    wb_valid_d    = 1'b1;
                    wb_reg_we_d   = 1'b0;
                    wb_rd_d       = req_rd_q;
                    wb_data_d     = 32'd0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops any outstanding request at once.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= {CNT_W{1'b0}};
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= {ADDR_WIDTH{1'b0}};
            mem_wdata_q   <= 32'd0;
            req_rd_q      <= 5'd0;
            wb_valid_q    <= 1'b0;
            wb_reg_we_q   <= 1'b0;
            wb_rd_q       <= 5'd0;
            wb_data_q     <= 32'd0;
            err_range_q   <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            req_rd_q      <= req_rd_d;
            wb_valid_q    <= wb_valid_d;
            wb_reg_we_q   <= wb_reg_we_d;
            wb_rd_q       <= wb_rd_d;
            wb_data_q     <= wb_data_d;
            err_range_q   <= err_range_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    // Output drive straight from the registers.
    always_comb begin
        in_ready    = (state_q == ST_IDLE);
        mem_req     = mem_req_q;
        mem_we      = mem_we_q;
        mem_addr    = mem_addr_q;
        mem_wdata   = mem_wdata_q;
        wb_valid    = wb_valid_q;
        wb_reg_we   = wb_reg_we_q;
        wb_rd       = wb_rd_q;
        wb_data     = wb_data_q;
        err_range   = err_range_q;
        err_timeout = err_timeout_q;
    end

endmodule
